// File: rtl/match_pkg.sv
// ---------------------------------------------------------------------------
// match_pkg
// Shared definitions for the air-hockey match controller and any block that
// needs to decode its outputs (score overlay, debug display).
//   match_state_t : match FSM states, encodings visible on match_state
//   WIN_*         : encodings of the winner output
//   SERVE_TO_*    : encodings of the serve_dir output
//   max3()        : helper used to size frame counters from frame parameters
// ---------------------------------------------------------------------------
package match_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_GOAL  = 3'd3,
      ST_OVER  = 3'd4
   } match_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam logic SERVE_TO_P1 = 1'b0;
   localparam logic SERVE_TO_P2 = 1'b1;

   // Largest of three frame counts, so one counter can serve every phase.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/frame_tick.sv
// ---------------------------------------------------------------------------
// frame_tick
// Turns the vsync level from the timing pipeline into a one-cycle frame tick
// on each rising edge of vsync. Reusable by any frame-paced block.
// Ports:
//   clk_in   : pixel clock
//   rst      : synchronous active-high reset
//   vsync_in : vsync level
//   tick     : registered one-cycle pulse, one per vsync rising edge
// ---------------------------------------------------------------------------
module frame_tick (
   input  logic clk_in,
   input  logic rst,
   input  logic vsync_in,
   output logic tick
);

   logic vsync_q;

   // The tick itself is registered so that the cycle right after reset can
   // never carry a tick, even if vsync is already high when reset drops.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         vsync_q <= 1'b0;
         tick    <= 1'b0;
      end else begin
         vsync_q <= vsync_in;
         tick    <= vsync_in & ~vsync_q;
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// match_sequencer
// Match-level controller for the air-hockey game: sequences the ball through
// idle, serve countdown, play, goal pause and game over, and owns both scores.
// Optional feature macro: SCORE_BLINK_EN (winner digit blinks in game over).
// Parameters:
//   WIN_SCORE    : score that ends the match (1..15)
//   SERVE_FRAMES : frames the ball is held centred before play
//   GOAL_FRAMES  : frames of freeze after a goal
//   BLINK_FRAMES : half-period of the winner-digit blink, in frames
// Ports:
//   clk_in, rst          : pixel clock, synchronous active-high reset
//   vsync_in             : vsync from the timing pipeline
//   start_btn            : debounced start level
//   goal_p1, goal_p2     : one-cycle goal pulses from the ball controller
//   ball_run             : ball motion enable level
//   ball_reset           : one-cycle pulse to recentre the ball
//   serve_dir            : 0 serves toward player 1, 1 toward player 2
//   player_1/2_score     : binary scores for the seven-segment mux
//   winner               : 00 none, 01 player 1, 10 player 2
//   match_state          : current state encoding
//   score_blank          : per-digit blank (bit0 player 1, bit1 player 2)
// ---------------------------------------------------------------------------
module match_sequencer
   import match_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 120,
   parameter int GOAL_FRAMES  = 90,
   parameter int BLINK_FRAMES = 30
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       start_btn,
   input  logic       goal_p1,
   input  logic       goal_p2,
   output logic       ball_run,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] player_1_score,
   output logic [3:0] player_2_score,
   output logic [1:0] winner,
   output logic [2:0] match_state,
   output logic [1:0] score_blank
);

   localparam int CNT_W = $clog2(max3(SERVE_FRAMES, GOAL_FRAMES, BLINK_FRAMES)) + 1;

   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0] GOAL_LOAD  = CNT_W'(GOAL_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);
`ifdef SCORE_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES);
`endif

   match_state_t     state;
   logic [CNT_W-1:0] frame_cnt;
   logic             frame_tk;
   logic             start_q;
   logic             start_evt;
   logic [3:0]       p1_next;
   logic [3:0]       p2_next;

   // Frame pacing comes from the shared vsync edge detector.
   frame_tick u_frame_tick (
      .clk_in   (clk_in),
      .rst      (rst),
      .vsync_in (vsync_in),
      .tick     (frame_tk)
   );

   // Start is edge-triggered so holding the button cannot restart a match.
   // Scores can never pass WIN_SCORE, so the 4-bit increment cannot wrap.
   assign start_evt   = start_btn & ~start_q;
   assign p1_next     = player_1_score + 4'd1;
   assign p2_next     = player_2_score + 4'd1;
   assign match_state = state;

`ifndef SCORE_BLINK_EN
   assign score_blank = 2'b00;
`endif

   // Match FSM, frame counter and scores. A new match may only begin from
   // IDLE or OVER; that case is handled ahead of the per-state logic. The
   // single frame counter counts down SERVE_FRAMES, GOAL_FRAMES or (in OVER)
   // the blink half-period; a tick in the cycle that loads it is consumed by
   // the old state and never counts against the new load. SERVE and GOAL
   // leave on the tick that takes the counter from 1 to 0.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state          <= ST_IDLE;
         frame_cnt      <= '0;
         start_q        <= 1'b0;
         ball_run       <= 1'b0;
         ball_reset     <= 1'b0;
         serve_dir      <= SERVE_TO_P1;
         player_1_score <= 4'd0;
         player_2_score <= 4'd0;
         winner         <= WIN_NONE;
`ifdef SCORE_BLINK_EN
         score_blank    <= 2'b00;
`endif
      end else begin
         start_q    <= start_btn;
         ball_reset <= 1'b0;

         if (start_evt && (state == ST_IDLE || state == ST_OVER)) begin
            state          <= ST_SERVE;
            frame_cnt      <= SERVE_LOAD;
            ball_run       <= 1'b0;
            ball_reset     <= 1'b1;
            serve_dir      <= SERVE_TO_P1;
            player_1_score <= 4'd0;
            player_2_score <= 4'd0;
            winner         <= WIN_NONE;
`ifdef SCORE_BLINK_EN
            score_blank    <= 2'b00;
`endif
         end else begin
            case (state)
               ST_IDLE: begin
                  ball_run <= 1'b0;
               end

               ST_SERVE: begin
                  if (frame_tk) begin
                     if (frame_cnt <= CNT_ONE) begin
                        frame_cnt <= '0;
                        state     <= ST_PLAY;
                        ball_run  <= 1'b1;
                     end else begin
                        frame_cnt <= frame_cnt - CNT_ONE;
                     end
                  end
               end

               ST_PLAY: begin
                  if (goal_p1) begin
                     player_1_score <= p1_next;
                     serve_dir      <= SERVE_TO_P2;
                     ball_run       <= 1'b0;
                     if (p1_next == WIN_VAL) begin
                        state  <= ST_OVER;
                        winner <= WIN_P1;
`ifdef SCORE_BLINK_EN
                        frame_cnt <= BLINK_LOAD;
`endif
                     end else begin
                        state     <= ST_GOAL;
                        frame_cnt <= GOAL_LOAD;
                     end
                  end else if (goal_p2) begin
                     player_2_score <= p2_next;
                     serve_dir      <= SERVE_TO_P1;
                     ball_run       <= 1'b0;
                     if (p2_next == WIN_VAL) begin
                        state  <= ST_OVER;
                        winner <= WIN_P2;
`ifdef SCORE_BLINK_EN
                        frame_cnt <= BLINK_LOAD;
`endif
                     end else begin
                        state     <= ST_GOAL;
                        frame_cnt <= GOAL_LOAD;
                     end
                  end
               end

               ST_GOAL: begin
                  if (frame_tk) begin
                     if (frame_cnt <= CNT_ONE) begin
                        frame_cnt  <= SERVE_LOAD;
                        state      <= ST_SERVE;
                        ball_reset <= 1'b1;
                     end else begin
                        frame_cnt <= frame_cnt - CNT_ONE;
                     end
                  end
               end

               ST_OVER: begin
                  ball_run <= 1'b0;
`ifdef SCORE_BLINK_EN
                  if (frame_tk) begin
                     if (frame_cnt <= CNT_ONE) begin
                        frame_cnt   <= BLINK_LOAD;
                        score_blank <= score_blank ^ winner;
                     end else begin
                        frame_cnt <= frame_cnt - CNT_ONE;
                     end
                  end
`endif
               end

               default: begin
                  state    <= ST_IDLE;
                  ball_run <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_match_sequencer.sv
// ---------------------------------------------------------------------------
// tb_match_sequencer
// Self-checking bench for match_sequencer with WIN_SCORE=3, SERVE_FRAMES=2,
// GOAL_FRAMES=3, BLINK_FRAMES=2. Honours SCORE_BLINK_EN when defined.
// ---------------------------------------------------------------------------
module tb_match_sequencer;

   localparam int WIN   = 3;
   localparam int SERVE = 2;
   localparam int GOALF = 3;
   localparam int BLINK = 2;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       vsync_in = 1'b0;
   logic       start_btn = 1'b0;
   logic       goal_p1 = 1'b0;
   logic       goal_p2 = 1'b0;
   logic       ball_run;
   logic       ball_reset;
   logic       serve_dir;
   logic [3:0] player_1_score;
   logic [3:0] player_2_score;
   logic [1:0] winner;
   logic [2:0] match_state;
   logic [1:0] score_blank;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase numbers, plain integer scores and a count of
   // frame ticks seen since the phase began.
   int m_phase, m_p1, m_p2, m_winner, m_dir, m_run, m_breset, m_blank;
   int m_ticks;
   bit m_vq, m_sq, m_tick;

   typedef struct {
      logic       rst, start, vsync, g1, g2;
      logic [2:0] e_state;
      logic [3:0] e_p1, e_p2;
      logic       e_run, e_breset, e_dir;
   } vec_t;

   vec_t table_v[20];

   match_sequencer #(
      .WIN_SCORE    (WIN),
      .SERVE_FRAMES (SERVE),
      .GOAL_FRAMES  (GOALF),
      .BLINK_FRAMES (BLINK)
   ) dut (
      .clk_in         (clk_in),
      .rst            (rst),
      .vsync_in       (vsync_in),
      .start_btn      (start_btn),
      .goal_p1        (goal_p1),
      .goal_p2        (goal_p2),
      .ball_run       (ball_run),
      .ball_reset     (ball_reset),
      .serve_dir      (serve_dir),
      .player_1_score (player_1_score),
      .player_2_score (player_2_score),
      .winner         (winner),
      .match_state    (match_state),
      .score_blank    (score_blank)
   );

   always #5 clk_in = ~clk_in;

   function automatic vec_t makeVec(input int r, input int s, input int v, input int a,
                                    input int b, input int st, input int p1, input int p2,
                                    input int run, input int br, input int dir);
      vec_t x;
      x.rst = r[0]; x.start = s[0]; x.vsync = v[0]; x.g1 = a[0]; x.g2 = b[0];
      x.e_state = st[2:0]; x.e_p1 = p1[3:0]; x.e_p2 = p2[3:0];
      x.e_run = run[0]; x.e_breset = br[0]; x.e_dir = dir[0];
      return x;
   endfunction

   task automatic newMatch();
      m_p1 = 0; m_p2 = 0; m_winner = 0; m_dir = 0;
      m_breset = 1; m_phase = 1; m_ticks = 0; m_blank = 0; m_run = 0;
   endtask

   task automatic scorePoint(input int who);
      m_run = 0;
      m_ticks = 0;
      if (who == 1) begin
         m_p1++;
         m_dir = 1;
      end else begin
         m_p2++;
         m_dir = 0;
      end
      if (m_p1 == WIN || m_p2 == WIN) begin
         m_phase = 4;
         m_winner = who;
         m_blank = 0;
      end else begin
         m_phase = 3;
      end
   endtask

   task automatic modelStep(input bit r, input bit s, input bit v, input bit a, input bit b);
      bit evt;
      bit tk;
      if (r) begin
         m_phase = 0; m_p1 = 0; m_p2 = 0; m_winner = 0; m_dir = 0;
         m_run = 0; m_breset = 0; m_blank = 0; m_ticks = 0;
         m_vq = 0; m_sq = 0; m_tick = 0;
      end else begin
         evt = s && !m_sq;
         tk = m_tick;
         m_breset = 0;
         if (evt && (m_phase == 0 || m_phase == 4)) begin
            newMatch();
         end else if (m_phase == 1) begin
            if (tk) m_ticks++;
            if (m_ticks == SERVE) begin
               m_phase = 2;
               m_run = 1;
            end
         end else if (m_phase == 2) begin
            if (a) scorePoint(1);
            else if (b) scorePoint(2);
         end else if (m_phase == 3) begin
            if (tk) m_ticks++;
            if (m_ticks == GOALF) begin
               m_phase = 1;
               m_ticks = 0;
               m_breset = 1;
            end
         end else if (m_phase == 4) begin
            if (tk) m_ticks++;
`ifdef SCORE_BLINK_EN
            m_blank = ((m_ticks / BLINK) % 2 == 1) ? m_winner : 0;
`endif
         end
         m_sq = s;
         m_tick = v && !m_vq;
         m_vq = v;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareModel();
      checkOutput("model{state,p1,p2,win,run,brst,dir,blank}",
                  32'({match_state, player_1_score, player_2_score, winner,
                       ball_run, ball_reset, serve_dir, score_blank}),
                  32'({3'(m_phase), 4'(m_p1), 4'(m_p2), 2'(m_winner),
                       1'(m_run), 1'(m_breset), 1'(m_dir), 2'(m_blank)}));
   endtask

   // One clock: drive inputs, clock the DUT and the model, sample at negedge.
   task automatic applyStimulus(input bit r, input bit s, input bit v, input bit a, input bit b);
      rst = r; start_btn = s; vsync_in = v; goal_p1 = a; goal_p2 = b;
      @(posedge clk_in);
      modelStep(r, s, v, a, b);
      @(negedge clk_in);
      compareModel();
   endtask

   task automatic frameTicks(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(0, 0, 1, 0, 0);
         applyStimulus(0, 0, 0, 0, 0);
      end
   endtask

   task automatic rally(input bit who_p1);
      frameTicks(SERVE);
      checkOutput("rally_play", 32'(match_state), 32'd2);
      applyStimulus(0, 0, 0, who_p1, !who_p1);
      frameTicks(GOALF);
   endtask

   logic [1:0] exp_blink_mid;

   initial begin
`ifdef SCORE_BLINK_EN
      exp_blink_mid = 2'b01;
`else
      exp_blink_mid = 2'b00;
`endif
      // rst start vs g1 g2 | state p1 p2 run brst dir
      table_v[0]  = makeVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      table_v[1]  = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      table_v[2]  = makeVec(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      table_v[3]  = makeVec(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      table_v[4]  = makeVec(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      table_v[5]  = makeVec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      table_v[6]  = makeVec(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      table_v[7]  = makeVec(0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0);
      table_v[8]  = makeVec(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0);
      table_v[9]  = makeVec(0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0);
      table_v[10] = makeVec(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
      table_v[11] = makeVec(0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0);
      table_v[12] = makeVec(0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
      table_v[13] = makeVec(0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0);
      table_v[14] = makeVec(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
      table_v[15] = makeVec(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      table_v[16] = makeVec(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      table_v[17] = makeVec(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      table_v[18] = makeVec(0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0);
      table_v[19] = makeVec(0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 1);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(table_v[i].rst, table_v[i].start, table_v[i].vsync,
                       table_v[i].g1, table_v[i].g2);
         checkOutput($sformatf("row%0d", i),
                     32'({match_state, player_1_score, player_2_score,
                          ball_run, ball_reset, serve_dir}),
                     32'({table_v[i].e_state, table_v[i].e_p1, table_v[i].e_p2,
                          table_v[i].e_run, table_v[i].e_breset, table_v[i].e_dir}));
      end
      checkOutput("reset_blank", 32'(score_blank), 32'd0);

      // Leave GOAL (1:1), then a goal during SERVE must be ignored.
      frameTicks(GOALF);
      checkOutput("goal_exit_state", 32'(match_state), 32'd1);
      checkOutput("goal_exit_reset", 32'(ball_reset), 32'd1);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("serve_goal_ignored", 32'({match_state, player_1_score}), 32'({3'd1, 4'd1}));
      frameTicks(SERVE);
      checkOutput("play_run", 32'({match_state, ball_run}), 32'({3'd2, 1'b1}));

      // Start edge during PLAY changes nothing.
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("play_start_ignored",
                  32'({match_state, player_1_score, player_2_score, ball_reset}),
                  32'({3'd2, 4'd1, 4'd1, 1'b0}));
      applyStimulus(0, 0, 0, 0, 0);

      // Two more player-1 points end the match.
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("p1_second", 32'({match_state, player_1_score, serve_dir}),
                  32'({3'd3, 4'd2, 1'b1}));
      frameTicks(GOALF);
      frameTicks(SERVE);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("match_over", 32'({match_state, player_1_score, winner, ball_run}),
                  32'({3'd4, 4'd3, 2'b01, 1'b0}));
      checkOutput("over_blank_entry", 32'(score_blank), 32'd0);
      frameTicks(BLINK);
      checkOutput("over_blank_mid", 32'(score_blank), 32'(exp_blink_mid));
      frameTicks(BLINK);
      checkOutput("over_blank_back", 32'({score_blank, player_1_score}), 32'({2'b00, 4'd3}));

      // Restart from OVER clears everything and recentres the ball.
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("restart",
                  32'({match_state, player_1_score, player_2_score, winner, ball_reset, serve_dir}),
                  32'({3'd1, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0}));
      applyStimulus(0, 0, 0, 0, 0);

      // Build up 2:1 and reset while in GOAL.
      rally(1);
      rally(1);
      frameTicks(SERVE);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("goal_2_1", 32'({match_state, player_1_score, player_2_score}),
                  32'({3'd3, 4'd2, 4'd1}));
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("mid_reset",
                  32'({match_state, player_1_score, player_2_score, ball_run, winner, score_blank}),
                  32'({3'd0, 4'd0, 4'd0, 1'b0, 2'b00, 2'b00}));

      // Randomised traffic against the model.
      begin
         bit s_lvl;
         s_lvl = 0;
         for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) s_lvl = !s_lvl;
            applyStimulus($urandom_range(0, 499) == 0, s_lvl, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
